load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage directly downstream of the ALU. Takes the registered ALU result as the effective byte address.
//  Drives a word-wide data-memory port with a req/gnt/rvalid handshake and per-byte lane enables.
//  Aligns and sign-/zero-extends load data, then hands the result with its tag to writeback.
//  Handles one access at a time (IDLE/REQ/WAIT FSM) and flags misaligned or illegal accesses without touching memory.
// PARAMETERS
//  DWIDTH   32  datapath width (fixed 32 for RV32 lane logic)
//  ADDR_W   10  word-address width on memory port (o_mem_addr = i_addr[ADDR_W+1:2])
//  TAG_W     4  writeback tag width (thread id / rd), carried through unchanged
// PORTS
//  clk           in   1        clock, all state on rising edge
//  reset         in   1        synchronous, active-high
//  i_valid       in   1        request present (qualified by o_ready)
//  o_ready       out  1        1 only in IDLE; request accepted when i_valid & o_ready
//  i_addr        in   DWIDTH   effective byte address (ALU o_result)
//  i_wdata       in   DWIDTH   store data (rs2)
//  i_funct3      in   3        size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  i_is_store    in   1        1 store, 0 load
//  i_tag         in   TAG_W    writeback tag
//  o_mem_req     out  1        memory request, held until i_mem_gnt
//  i_mem_gnt     in   1        memory accepts request this cycle
//  o_mem_addr    out  ADDR_W   word address
//  o_mem_we      out  1        write enable
//  o_mem_be      out  4        byte-lane enables
//  o_mem_wdata   out  DWIDTH   lane-replicated store data
//  i_mem_rvalid  in   1        read data valid
//  i_mem_rdata   in   DWIDTH   read word
//  o_wb_valid    out  1        1-cycle pulse: load result valid
//  o_wb_data     out  DWIDTH   extended load result
//  o_wb_tag      out  TAG_W    tag of completed access
//  o_st_done     out  1        1-cycle pulse: store granted
//  o_fault       out  1        1-cycle pulse: misaligned/illegal, no memory access
// BEHAVIOUR
//  Reset: state=IDLE. o_mem_req, o_mem_we, o_wb_valid, o_st_done, o_fault = 0. o_mem_be = 0.
//    o_mem_addr, o_mem_wdata, o_wb_data, o_wb_tag = 0.
//  IDLE: accept on i_valid. Latch addr/data/funct3/store/tag.
//    Fault cases: H with addr[0]=1; W with addr[1:0]!=0; funct3 in {011,110,111}; funct3 1xx on a store.
//    On fault: o_fault=1 next cycle with o_wb_tag=i_tag, stay IDLE. Otherwise -> REQ.
//  REQ: o_mem_req=1; addr/we/be/wdata stable until gnt.
//    On i_mem_gnt: store -> o_st_done=1 next cycle, go IDLE; load -> WAIT.
//  WAIT: on i_mem_rvalid, register the extracted result.
//    o_wb_valid=1 next cycle, o_wb_data and o_wb_tag valid in that same cycle; go IDLE.
//  Lane enables: B = 4'b0001<<addr[1:0]; H = 4'b0011<<{addr[1],1'b0}; W = 4'b1111.
//    Loads drive the same be with we=0.
//  Store data: B={4{d[7:0]}}, H={2{d[15:0]}}, W=d.
//  Load extract: byte = rdata>>(8*addr[1:0]); half = rdata>>(16*addr[1]).
//    Then sign-extend (000/001) or zero-extend (100/101); W passes rdata.
//  Timing, gnt same cycle as req and rvalid one cycle later:
//    load: accept N, req N+1, rvalid N+2, o_wb_valid N+3.
//    store: accept N, req+gnt N+1, o_st_done N+2.
//  o_ready is low in REQ/WAIT and in the cycle a pulse output is driven is still IDLE (back-to-back accepts allowed).
//  i_valid while busy: ignored (not accepted).
//  i_mem_gnt outside REQ: ignored. i_mem_rvalid outside WAIT: ignored.
//  Pulses (o_wb_valid, o_st_done, o_fault) last exactly one cycle.
//  Reset mid-operation: FSM -> IDLE, o_mem_req drops next edge, in-flight rvalid discarded, no wb/done pulse.
// TESTING
//  LB addr=0x103, rdata=0x80FF_1234 -> be=1000, o_wb_data=0xFFFF_FF80, tag echoed, wb at N+3.
//  LHU addr=0x102, rdata=0x8001_0000 -> be=1100, o_wb_data=0x0000_8001; LH same -> 0xFFFF_8001.
//  SB addr=0x201 data=0x0000_00AB -> be=0010, wdata=0xABAB_ABAB, we=1, mem_addr=0x080, o_st_done at N+2.
//  SW addr=0x006 -> o_fault pulse, no o_mem_req ever; funct3=011 load -> o_fault.
//  Gnt withheld 5 cycles: req/addr/be/wdata stable, o_ready=0, extra i_valid not accepted.
//  Reset asserted in WAIT, then rvalid arrives -> no o_wb_valid; FSM IDLE, o_ready=1.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// =============================================================================
// Module   : load_store_unit
// Brief    : Single-outstanding load/store stage with req/gnt/rvalid memory
//            port, byte-lane steering, load extension and fault detection.
// Revision : 1.0
// =============================================================================
module load_store_unit #(
    parameter int DWIDTH = 32,
    parameter int ADDR_W = 10,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DWIDTH-1:0] i_addr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic [2:0]        i_funct3,
    input  logic              i_is_store,
    input  logic [TAG_W-1:0]  i_tag,
    output logic              o_mem_req,
    input  logic              i_mem_gnt,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_be,
    output logic [DWIDTH-1:0] o_mem_wdata,
    input  logic              i_mem_rvalid,
    input  logic [DWIDTH-1:0] i_mem_rdata,
    output logic              o_wb_valid,
    output logic [DWIDTH-1:0] o_wb_data,
    output logic [TAG_W-1:0]  o_wb_tag,
    output logic              o_st_done,
    output logic              o_fault
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [DWIDTH-1:0] r_mem_wdata;
    logic              r_is_store;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic [TAG_W-1:0]  r_tag;
    logic              r_wb_valid;
    logic [DWIDTH-1:0] r_wb_data;
    logic [TAG_W-1:0]  r_wb_tag;
    logic              r_st_done;
    logic              r_fault;

    logic              w_accept;
    logic              w_fault;
    logic [3:0]        w_be;
    logic [DWIDTH-1:0] w_wdata;
    logic [DWIDTH-1:0] w_shift_b;
    logic [DWIDTH-1:0] w_shift_h;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DWIDTH-1:0] w_ld;
    logic              w_unused_addr;

    assign w_unused_addr = ^{i_addr[DWIDTH-1:ADDR_W+2]};
    assign w_accept      = i_valid & o_ready;

    // Misaligned halves/words, reserved encodings and unsigned-size stores all fault
    always_comb begin
        w_fault = 1'b1;
        case (i_funct3)
            c_F3_B:          w_fault = 1'b0;
            c_F3_H:          w_fault = i_addr[0];
            c_F3_W:          w_fault = (i_addr[1:0] != 2'b00);
            c_F3_BU, c_F3_HU: w_fault = i_is_store;
            default:         w_fault = 1'b1;
        endcase
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {i_addr[1], 1'b0};
                w_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = i_wdata;
            end
        endcase
    end

    assign w_shift_b = i_mem_rdata >> {r_addr_lo, 3'b000};
    assign w_shift_h = i_mem_rdata >> {r_addr_lo[1], 4'b0000};
    assign w_byte    = w_shift_b[7:0];
    assign w_half    = w_shift_h[15:0];

    always_comb begin
        w_ld = i_mem_rdata;
        case (r_funct3)
            c_F3_B:  w_ld = {{(DWIDTH-8){w_byte[7]}}, w_byte};
            c_F3_H:  w_ld = {{(DWIDTH-16){w_half[15]}}, w_half};
            c_F3_BU: w_ld = {{(DWIDTH-8){1'b0}}, w_byte};
            c_F3_HU: w_ld = {{(DWIDTH-16){1'b0}}, w_half};
            default: w_ld = i_mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && !w_fault) w_next = S_REQ;
            S_REQ:   if (i_mem_gnt) w_next = r_is_store ? S_IDLE : S_WAIT;
            S_WAIT:  if (i_mem_rvalid) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready   = (r_state == S_IDLE);
        o_mem_req = (r_state == S_REQ);
        o_mem_we  = (r_state == S_REQ) & r_is_store;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_is_store  <= 1'b0;
            r_funct3    <= '0;
            r_addr_lo   <= '0;
            r_tag       <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_data   <= '0;
            r_wb_tag    <= '0;
            r_st_done   <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_st_done  <= 1'b0;
            r_fault    <= 1'b0;
            if (w_accept) begin
                if (w_fault) begin
                    r_fault  <= 1'b1;
                    r_wb_tag <= i_tag;
                end else begin
                    r_mem_addr  <= i_addr[ADDR_W+1:2];
                    r_mem_be    <= w_be;
                    r_mem_wdata <= w_wdata;
                    r_is_store  <= i_is_store;
                    r_funct3    <= i_funct3;
                    r_addr_lo   <= i_addr[1:0];
                    r_tag       <= i_tag;
                end
            end
            if ((r_state == S_REQ) && i_mem_gnt && r_is_store) begin
                r_st_done <= 1'b1;
                r_wb_tag  <= r_tag;
            end
            if ((r_state == S_WAIT) && i_mem_rvalid) begin
                r_wb_valid <= 1'b1;
                r_wb_data  <= w_ld;
                r_wb_tag   <= r_tag;
            end
        end
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_be    = r_mem_be;
    assign o_mem_wdata = r_mem_wdata;
    assign o_wb_valid  = r_wb_valid;
    assign o_wb_data   = r_wb_data;
    assign o_wb_tag    = r_wb_tag;
    assign o_st_done   = r_st_done;
    assign o_fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// =============================================================================
// Module   : tb_load_store_unit
// Brief    : Directed bench for load_store_unit with a pulse scoreboard.
// Revision : 1.0
// =============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic [2:0]  i_funct3 = '0;
    logic        i_is_store = 1'b0;
    logic [3:0]  i_tag = '0;
    logic        o_mem_req;
    logic        i_mem_gnt;
    logic [9:0]  o_mem_addr;
    logic        o_mem_we;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_wb_valid;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_tag;
    logic        o_st_done;
    logic        o_fault;

    logic        auto_mem = 1'b1;
    logic        auto_gnt = 1'b0;
    logic        auto_rv  = 1'b0;
    logic        gnt_st   = 1'b0;
    logic        man_gnt  = 1'b0;
    logic        man_rv   = 1'b0;
    logic [31:0] mem_rdata = '0;

    assign i_mem_gnt    = auto_gnt | man_gnt;
    assign i_mem_rvalid = auto_rv | man_rv;
    assign i_mem_rdata  = mem_rdata;

    load_store_unit #(.DWIDTH(32), .ADDR_W(10), .TAG_W(4)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_funct3(i_funct3),
        .i_is_store(i_is_store), .i_tag(i_tag),
        .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt),
        .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
        .o_mem_wdata(o_mem_wdata), .i_mem_rvalid(i_mem_rvalid),
        .i_mem_rdata(i_mem_rdata), .o_wb_valid(o_wb_valid),
        .o_wb_data(o_wb_data), .o_wb_tag(o_wb_tag),
        .o_st_done(o_st_done), .o_fault(o_fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  kind;   // {wb_valid, st_done, fault}
        logic [31:0] data;
        logic [3:0]  tag;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Zero-latency memory: grant as soon as a request is seen, read data one cycle later
    always @(negedge clk) begin
        auto_rv = 1'b0;
        if (auto_gnt) begin
            auto_gnt = 1'b0;
            if (!gnt_st) auto_rv = 1'b1;
        end else if (auto_mem && o_mem_req) begin
            auto_gnt = 1'b1;
            gnt_st   = o_mem_we;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (o_wb_valid | o_st_done | o_fault) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {29'd0, o_wb_valid, o_st_done, o_fault}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", {29'd0, o_wb_valid, o_st_done, o_fault}, {29'd0, e.kind});
                chk("pulse_tag", {28'd0, o_wb_tag}, {28'd0, e.tag});
                if (e.kind == 3'b100) chk("wb_data", o_wb_data, e.data);
                if (e.cyc >= 0) chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    // kind==0 means no completion pulse is expected
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                         input logic st, input logic [3:0] tag, input logic [2:0] kind,
                         input logic [31:0] wbd, input int lat);
        int   n = 0;
        exp_t e;
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) chk("ready_timeout", {31'd0, o_ready}, 32'd1);
        i_valid = 1'b1; i_addr = a; i_wdata = d; i_funct3 = f3; i_is_store = st; i_tag = tag;
        e.kind = kind; e.data = wbd; e.tag = tag; e.cyc = (lat < 0) ? -1 : cyc + lat;
        if (kind != 3'b000) sb.push_back(e);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !o_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready_req_we", {29'd0, o_ready, o_mem_req, o_mem_we}, 32'b100);
        chk("rst_pulses", {29'd0, o_wb_valid, o_st_done, o_fault}, 32'd0);
        chk("rst_be_addr", {18'd0, o_mem_be, o_mem_addr}, 32'd0);
        chk("rst_wdata", o_mem_wdata, 32'd0);
        chk("rst_wb", {o_wb_data[27:0], o_wb_tag}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        mem_rdata = 32'h80FF_1234;
        issue(32'h103, 32'h0, 3'b000, 1'b0, 4'd5, 3'b100, 32'hFFFF_FF80, 3);
        chk("lb_be", {28'd0, o_mem_be}, 32'b1000);
        chk("lb_req_we_rdy", {29'd0, o_mem_req, o_mem_we, o_ready}, 32'b100);
        chk("lb_addr", {22'd0, o_mem_addr}, 32'h40);
        drain();

        mem_rdata = 32'h8001_0000;
        issue(32'h102, 32'h0, 3'b101, 1'b0, 4'd6, 3'b100, 32'h0000_8001, 3);
        chk("lhu_be", {28'd0, o_mem_be}, 32'b1100);
        drain();
        issue(32'h102, 32'h0, 3'b001, 1'b0, 4'd7, 3'b100, 32'hFFFF_8001, 3);
        drain();
        mem_rdata = 32'hDEAD_BEEF;
        issue(32'h004, 32'h0, 3'b010, 1'b0, 4'd8, 3'b100, 32'hDEAD_BEEF, 3);
        chk("lw_be", {28'd0, o_mem_be}, 32'hF);
        drain();
        mem_rdata = 32'h0000_9A00;
        issue(32'h001, 32'h0, 3'b100, 1'b0, 4'd4, 3'b100, 32'h0000_009A, 3);
        drain();

        issue(32'h201, 32'h0000_00AB, 3'b000, 1'b1, 4'd9, 3'b010, 32'h0, 2);
        chk("sb_be", {28'd0, o_mem_be}, 32'b0010);
        chk("sb_wdata", o_mem_wdata, 32'hABAB_ABAB);
        chk("sb_req_we", {30'd0, o_mem_req, o_mem_we}, 32'b11);
        chk("sb_addr", {22'd0, o_mem_addr}, 32'h080);
        drain();
        issue(32'h202, 32'h1234_CDEF, 3'b001, 1'b1, 4'd3, 3'b010, 32'h0, 2);
        chk("sh_be", {28'd0, o_mem_be}, 32'b1100);
        chk("sh_wdata", o_mem_wdata, 32'hCDEF_CDEF);
        drain();

        issue(32'h006, 32'h0, 3'b010, 1'b1, 4'd10, 3'b001, 32'h0, 1);
        chk("fault_ready", {31'd0, o_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("fault_no_req", {31'd0, o_mem_req}, 32'd0);
            @(negedge clk);
        end
        issue(32'h000, 32'h0, 3'b011, 1'b0, 4'd11, 3'b001, 32'h0, 1);
        chk("f3_011_no_req", {31'd0, o_mem_req}, 32'd0);
        issue(32'h000, 32'h0, 3'b100, 1'b1, 4'd2, 3'b001, 32'h0, 1);
        issue(32'h101, 32'h0, 3'b001, 1'b0, 4'd1, 3'b001, 32'h0, 1);
        chk("mis_h_no_req", {31'd0, o_mem_req}, 32'd0);
        drain();

        auto_mem = 1'b0;
        issue(32'h00C, 32'h1122_3344, 3'b010, 1'b1, 4'd12, 3'b010, 32'h0, -1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_req_we_rdy", {29'd0, o_mem_req, o_mem_we, o_ready}, 32'b110);
            chk("stall_addr", {22'd0, o_mem_addr}, 32'h3);
            chk("stall_be", {28'd0, o_mem_be}, 32'hF);
            chk("stall_wdata", o_mem_wdata, 32'h1122_3344);
            if (i == 1) begin
                i_valid = 1'b1; i_addr = 32'h20; i_funct3 = 3'b010; i_is_store = 1'b0;
                i_tag = 4'd15; man_rv = 1'b1;
            end else begin
                i_valid = 1'b0; man_rv = 1'b0;
            end
            @(negedge clk);
        end
        i_valid = 1'b0; man_rv = 1'b0; man_gnt = 1'b1;
        @(negedge clk);
        man_gnt = 1'b0;
        chk("stall_done_ready", {31'd0, o_ready}, 32'd1);
        drain();

        mem_rdata = 32'h5555_AAAA;
        issue(32'h010, 32'h0, 3'b010, 1'b0, 4'd13, 3'b000, 32'h0, -1);
        man_gnt = 1'b1;
        @(negedge clk);
        man_gnt = 1'b0;
        chk("wait_state", {30'd0, o_mem_req, o_ready}, 32'b00);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; man_rv = 1'b1;
        @(negedge clk);
        man_rv = 1'b0;
        chk("rst_wait_ready_req", {30'd0, o_ready, o_mem_req}, 32'b10);
        for (int i = 0; i < 3; i++) begin
            chk("rst_wait_no_wb", {31'd0, o_wb_valid}, 32'd0);
            @(negedge clk);
        end

        auto_mem = 1'b1;
        mem_rdata = 32'h7F00_0000;
        issue(32'h003, 32'h0, 3'b000, 1'b0, 4'd14, 3'b100, 32'h0000_007F, 3);
        drain();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
